// File: rtl/shift_exec_stage_pkg.sv
// Shared encodings for the shift execute stage.
// Holds op codes, buffer state encoding and datapath widths.
package shift_exec_stage_pkg;

    localparam int DATA_W = 32;
    localparam int AMT_W  = 5;

    typedef enum logic [1:0] {
        SHOP_SLL  = 2'b00,
        SHOP_SRL  = 2'b01,
        SHOP_SRA  = 2'b10,
        SHOP_ROTL = 2'b11
    } shop_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_e;

endpackage

// File: rtl/sll.sv
// Logical left shift, zero-filled.
// Shared left-shift unit used by the execute stages.
module sll
    import shift_exec_stage_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [AMT_W-1:0]  amt,
    output logic [DATA_W-1:0] result
);

    assign result = data << amt;

endmodule

// File: rtl/sra.sv
// Right shift with selectable fill bit.
// fill=0 gives a logical shift, fill=data[31] an arithmetic one.
module sra
    import shift_exec_stage_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [AMT_W-1:0]  amt,
    input  logic              fill,
    output logic [DATA_W-1:0] result
);

    logic signed [DATA_W:0] ext;
    logic signed [DATA_W:0] shifted;

    assign ext     = {fill, data};
    assign shifted = ext >>> amt;
    assign result  = shifted[DATA_W-1:0];

endmodule

// File: rtl/shift_exec_stage.sv
// Shift execute stage with a two-entry skid buffer on the output.
// Define SHIFT_ROTATE_EN to make op 11 a rotate-left instead of sll.
module shift_exec_stage
    import shift_exec_stage_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [AMT_W-1:0]  in_amt,
    input  logic [1:0]        in_op,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_zero,
    output logic [15:0]       op_count
);

    shop_e             op;
    logic [DATA_W-1:0] sll_res;
    logic [DATA_W-1:0] sr_res;
    logic [DATA_W-1:0] res;
    logic              fill;

    assign op   = shop_e'(in_op);
    assign fill = (op == SHOP_SRA) && in_data[DATA_W-1];

    sll u_sll (
        .data   (in_data),
        .amt    (in_amt),
        .result (sll_res)
    );

    sra u_sra (
        .data   (in_data),
        .amt    (in_amt),
        .fill   (fill),
        .result (sr_res)
    );

`ifdef SHIFT_ROTATE_EN
    // Right part of the rotate: shift by (32-amt) mod 32; amt 0 folds to data|data.
    logic [AMT_W-1:0]  rot_amt;
    logic [DATA_W-1:0] rot_hi;
    logic [DATA_W-1:0] rot_res;

    assign rot_amt = ~in_amt + 5'd1;

    sra u_rot (
        .data   (in_data),
        .amt    (rot_amt),
        .fill   (1'b0),
        .result (rot_hi)
    );

    assign rot_res = sll_res | rot_hi;
`endif

    always_comb begin
        res = sll_res;
        unique case (op)
            SHOP_SLL:  res = sll_res;
            SHOP_SRL:  res = sr_res;
            SHOP_SRA:  res = sr_res;
`ifdef SHIFT_ROTATE_EN
            SHOP_ROTL: res = rot_res;
`else
            SHOP_ROTL: res = sll_res;
`endif
            default:   res = sll_res;
        endcase
    end

    state_e state;
    state_e state_n;
    logic   accept;
    logic   drain;
    logic   load_main;
    logic   load_skid;
    logic   move_skid;

    assign accept    = in_valid && in_ready;
    assign out_valid = (state != ST_EMPTY);
    assign drain     = out_valid && out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_n;
            in_ready <= (state_n != ST_FULL);
        end
    end

    always_comb begin
        state_n   = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        if (flush) begin
            state_n = ST_EMPTY;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_n   = ST_ONE;
                        load_main = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && !drain) begin
                        state_n   = ST_FULL;
                        load_skid = 1'b1;
                    end else if (!accept && drain) begin
                        state_n = ST_EMPTY;
                    end else if (accept && drain) begin
                        load_main = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        state_n   = ST_ONE;
                        move_skid = 1'b1;
                    end
                end
                default: state_n = ST_EMPTY;
            endcase
        end
    end

    logic [DATA_W-1:0] skid_data;
    logic [TAG_W-1:0]  skid_tag;
    logic              skid_zero;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_tag   <= '0;
            out_zero  <= 1'b1;
            skid_data <= '0;
            skid_tag  <= '0;
            skid_zero <= 1'b1;
        end else begin
            if (load_main) begin
                out_data <= res;
                out_tag  <= in_tag;
                out_zero <= (res == '0);
            end else if (move_skid) begin
                out_data <= skid_data;
                out_tag  <= skid_tag;
                out_zero <= skid_zero;
            end
            if (load_skid) begin
                skid_data <= res;
                skid_tag  <= in_tag;
                skid_zero <= (res == '0);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_count <= '0;
        end else if (accept && !flush) begin
            op_count <= op_count + 16'd1;
        end
    end

endmodule
